matmul_sequencer: RTL and testbench

Sequences one square matrix multiply C = A × B over the shared single-MAC datapath, between the UART receive phase and the UART transmit phase. On a start pulse it walks the (i, j, k) loop nest, issues read addresses to the A and B operand buffers, drives the MAC enable/first-product strobes, and writes each finished dot product into the C buffer. It pulses done when all N² results are written; the top-level control FSM consumes that pulse as its multiply-done input.

---
 rtl/matmul_pkg.sv | 32 +++
 rtl/matmul_idx_counter.sv | 70 +++++++
 rtl/matmul_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// ============================================================================
// Module      : matmul_pkg
// Description : Shared definitions for the matrix-multiply sequencer:
//               sequencer state encoding, default matrix dimension and the
//               index/address widths derived from it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matmul_pkg;

    // Default matrix dimension (N x N operands).
    localparam int MATMUL_N = 3;

    // Width of one loop index (i, j or k) for the default dimension.
    localparam int IDX_W = $clog2(MATMUL_N);

    // Width of an A/B/C buffer address for the default dimension.
    localparam int ADDR_W = $clog2(MATMUL_N * MATMUL_N);

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

endpackage : matmul_pkg

`default_nettype wire

// File: rtl/matmul_idx_counter.sv
// ============================================================================
// Module      : matmul_idx_counter
// Description : Nested (i, j, k) loop counter for the matrix multiply.
//               k is the inner dot-product index; (i, j) selects the output
//               element and advances row-major, j fastest.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   clr      in   clear i, j, k to 0 (highest priority)
//   inc_k    in   advance k, wrapping to 0 after N-1
//   inc_ij   in   advance j, wrapping into i; (N-1, N-1) wraps to (0, 0)
//   i, j, k  out  current loop indices
//   last_k   out  k == N-1
//   last_ij  out  (i, j) == (N-1, N-1)
// ============================================================================
`default_nettype none

module matmul_idx_counter
    import matmul_pkg::*;
#(
    parameter int N  = MATMUL_N,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc_k,
    input  logic          inc_ij,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic [IW-1:0] k,
    output logic          last_k,
    output logic          last_ij
);

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    assign last_k  = (k == IDX_LAST);
    assign last_ij = (i == IDX_LAST) && (j == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (clr) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            if (inc_k) begin
                k <= last_k ? '0 : k + IDX_ONE;
            end
            if (inc_ij) begin
                if (j == IDX_LAST) begin
                    j <= '0;
                    i <= (i == IDX_LAST) ? '0 : i + IDX_ONE;
                end else begin
                    j <= j + IDX_ONE;
                end
            end
        end
    end

endmodule : matmul_idx_counter

`default_nettype wire

// File: rtl/matmul_sequencer.sv
// ============================================================================
// Module      : matmul_sequencer
// Description : Sequences one square matrix multiply C = A x B over a single
//               shared MAC. Walks the (i, j, k) loop nest, issues A/B buffer
//               reads, drives the MAC enable / first-product strobes and
//               writes each finished dot product into the C buffer. Pulses
//               done after the last of the N*N results is written.
// Revision    : 1.0 - initial release
//
// Optional feature macro:
//   MATMUL_SEQ_PERF_EN - adds a 32-bit cycle_cnt output counting busy cycles
//                        of the most recent run.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset (aborts a run)
//   start      in   begin a multiply; honoured only when idle
//   busy       out  sequencer is not idle
//   done       out  one-cycle pulse after the last C write
//   rd_en      out  A/B buffer read strobe (1-cycle read latency)
//   a_addr     out  A read address, i*N + k
//   b_addr     out  B read address, k*N + j
//   mac_en     out  MAC enable, aligned with A/B read data
//   mac_first  out  MAC loads the product instead of accumulating
//   c_we       out  C buffer write strobe; MAC result valid
//   c_addr     out  C write address, i*N + j
//   cycle_cnt  out  busy cycles of the last run (MATMUL_SEQ_PERF_EN only)
// ============================================================================
`default_nettype none

module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N  = MATMUL_N,
    parameter int AW = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_en,
    output logic          mac_first,
    output logic          c_we,
    output logic [AW-1:0] c_addr
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]   cycle_cnt
`endif
);

    localparam int            IW   = $clog2(N);
    localparam logic [AW-1:0] N_AW = AW'(N);

    seq_state_t    state;
    seq_state_t    state_nxt;

    logic          clr;
    logic          inc_k;
    logic          inc_ij;
    logic [IW-1:0] i;
    logic [IW-1:0] j;
    logic [IW-1:0] k;
    logic          last_k;
    logic          last_ij;

    logic [AW-1:0] i_ext;
    logic [AW-1:0] j_ext;
    logic [AW-1:0] k_ext;

    // ------------------------------------------------------------------
    // Loop-nest counter
    // ------------------------------------------------------------------
    matmul_idx_counter #(
        .N  (N),
        .IW (IW)
    ) u_idx (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .inc_k   (inc_k),
        .inc_ij  (inc_ij),
        .i       (i),
        .j       (j),
        .k       (k),
        .last_k  (last_k),
        .last_ij (last_ij)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        inc_k     = 1'b0;
        inc_ij    = 1'b0;
        rd_en     = 1'b0;
        c_we      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                rd_en = 1'b1;
                // k wraps back to 0 on its last step, ready for the next element.
                inc_k = 1'b1;
                if (last_k) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The final product reaches the MAC during this cycle.
                state_nxt = WRITE;
            end
            WRITE: begin
                c_we   = 1'b1;
                inc_ij = 1'b1;
                state_nxt = last_ij ? DONE : FETCH;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Address arithmetic; addresses are held at 0 outside their strobes
    // so an idle or reset sequencer presents an all-zero interface.
    // ------------------------------------------------------------------
    assign i_ext = AW'(i);
    assign j_ext = AW'(j);
    assign k_ext = AW'(k);

    assign a_addr = rd_en ? (i_ext * N_AW + k_ext) : '0;
    assign b_addr = rd_en ? (k_ext * N_AW + j_ext) : '0;
    assign c_addr = c_we  ? (i_ext * N_AW + j_ext) : '0;

    // ------------------------------------------------------------------
    // MAC control: one cycle behind the read strobe so it lines up with
    // the buffer read data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_en    <= 1'b0;
            mac_first <= 1'b0;
        end else begin
            mac_en    <= rd_en;
            mac_first <= rd_en && (k == '0);
        end
    end

`ifdef MATMUL_SEQ_PERF_EN
    // ------------------------------------------------------------------
    // Busy-cycle counter. It also counts the DONE cycle, so once back in
    // IDLE it holds the full start-to-done latency until the next start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
        end else if ((state == IDLE) && start) begin
            cycle_cnt <= 32'd0;
        end else if (state != IDLE) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule : matmul_sequencer

`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
// ============================================================================
// Module      : tb_matmul_sequencer
// Description : Self-checking bench for matmul_sequencer (N = 3). Random and
//               directed operand matrices are multiplied through behavioural
//               1-cycle buffers and a MAC; results, address order, strobe
//               alignment, latency and reset abort are compared against a
//               plain loop-nest reference computed in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_sequencer;

    localparam int N       = 3;
    localparam int NN      = N * N;
    localparam int AW      = $clog2(NN);
    localparam int RUN_CYC = NN * (N + 2) + 1;   // start edge to done cycle

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          mac_en;
    logic          mac_first;
    logic          c_we;
    logic [AW-1:0] c_addr;
`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0]   cycle_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    matmul_sequencer #(
        .N  (N),
        .AW (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .mac_en    (mac_en),
        .mac_first (mac_first),
        .c_we      (c_we),
        .c_addr    (c_addr)
`ifdef MATMUL_SEQ_PERF_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    // ------------------------------------------------------------------
    // Behavioural operand buffers (1-cycle read) and MAC
    // ------------------------------------------------------------------
    int          a_mem [NN];
    int          b_mem [NN];
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] acc;

    always @(posedge clk) begin
        if (rd_en) begin
            a_q <= (int'(a_addr) < NN) ? 32'(a_mem[int'(a_addr)]) : 32'hDEAD;
            b_q <= (int'(b_addr) < NN) ? 32'(b_mem[int'(b_addr)]) : 32'hDEAD;
        end
        if (mac_en) begin
            acc <= mac_first ? (a_q * b_q) : (acc + a_q * b_q);
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // One full multiply. start is held for 'hold' sampled edges; with
    // 'repulse' set it is pulsed again twice while the run is busy.
    // ------------------------------------------------------------------
    task automatic do_run(input int hold, input bit repulse);
        int     c_exp [NN];
        int     exp_rd [$];
        int     rd_q [$];
        int     cw_addr [$];
        longint cw_val [$];
        int     n;
        int     mac_idx;
        bit     seen_done;
        int     s;

        for (int ii = 0; ii < N; ii++) begin
            for (int jj = 0; jj < N; jj++) begin
                s = 0;
                for (int kk = 0; kk < N; kk++) begin
                    s += a_mem[ii*N + kk] * b_mem[kk*N + jj];
                    exp_rd.push_back((ii*N + kk) * 256 + (kk*N + jj));
                end
                c_exp[ii*N + jj] = s;
            end
        end

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n         = 0;
        mac_idx   = 0;
        seen_done = 1'b0;

        while (!seen_done && n < RUN_CYC + 20) begin
            @(negedge clk);
            n++;
            start = (n < hold) || (repulse && (n == 20 || n == 35));
            check_eq("busy_run", longint'(busy), longint'(n <= RUN_CYC));
            if (rd_en) rd_q.push_back(int'(a_addr) * 256 + int'(b_addr));
            if (mac_en) begin
                check_eq("mac_first", longint'(mac_first), longint'((mac_idx % N) == 0));
                mac_idx++;
            end
            if (c_we) begin
                cw_addr.push_back(int'(c_addr));
                cw_val.push_back(longint'(acc));
            end
            if (done) begin
                seen_done = 1'b1;
                check_eq("done_latency", n, RUN_CYC);
            end
        end
        start = 1'b0;
        if (!seen_done) check_eq("done_timeout", 0, 1);

        check_eq("rd_count", rd_q.size(), N * NN);
        for (int e = 0; e < rd_q.size() && e < exp_rd.size(); e++)
            check_eq("rd_addr_pair", rd_q[e], exp_rd[e]);
        check_eq("mac_count", mac_idx, N * NN);
        check_eq("c_we_count", cw_addr.size(), NN);
        for (int e = 0; e < cw_addr.size() && e < NN; e++) begin
            check_eq("c_addr_order", cw_addr[e], e);
            check_eq("c_value", cw_val[e], c_exp[e]);
        end

        // After done: idle, quiet, and no second run from the extra starts.
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            check_eq("idle_quiet", longint'({busy, done, c_we, rd_en, mac_en, mac_first}), 0);
`ifdef MATMUL_SEQ_PERF_EN
            check_eq("cycle_cnt", longint'(cycle_cnt), RUN_CYC);
`endif
        end
    endtask

    // ------------------------------------------------------------------
    // Reset during the second FETCH cycle of element (1,1): cycle n = 22
    // counting from the start edge (element 4 occupies n = 21..25).
    // ------------------------------------------------------------------
    task automatic abort_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("abort_rd_en", longint'(rd_en), 1);
        check_eq("abort_a_addr", longint'(a_addr), 4);
        check_eq("abort_b_addr", longint'(b_addr), 4);
        rst = 1'b1;
        #1;
        check_eq("rst_strobes", longint'({busy, done, rd_en, mac_en, mac_first, c_we}), 0);
        check_eq("rst_addrs", longint'({a_addr, b_addr, c_addr}), 0);
`ifdef MATMUL_SEQ_PERF_EN
        check_eq("rst_cycle_cnt", longint'(cycle_cnt), 0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            check_eq("post_rst_quiet", longint'({busy, done, c_we, rd_en}), 0);
        end
    endtask

    task automatic fill_random();
        for (int e = 0; e < NN; e++) begin
            a_mem[e] = int'($urandom_range(255, 0));
            b_mem[e] = int'($urandom_range(255, 0));
        end
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(negedge clk);
        check_eq("reset_strobes", longint'({busy, done, rd_en, mac_en, mac_first, c_we}), 0);
        check_eq("reset_addrs", longint'({a_addr, b_addr, c_addr}), 0);
`ifdef MATMUL_SEQ_PERF_EN
        check_eq("reset_cycle_cnt", longint'(cycle_cnt), 0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_after_reset", longint'(busy), 0);

        // Random operands, single-cycle start
        fill_random();
        do_run(1, 1'b0);

        // Identity times 1..9: result must reproduce B
        for (int ii = 0; ii < N; ii++) begin
            for (int jj = 0; jj < N; jj++) begin
                a_mem[ii*N + jj] = (ii == jj) ? 1 : 0;
                b_mem[ii*N + jj] = ii*N + jj + 1;
            end
        end
        do_run(1, 1'b0);

        // start held 5 cycles and re-pulsed while busy: exactly one run
        fill_random();
        do_run(5, 1'b1);

        // Abort mid-run, then a clean run afterwards
        fill_random();
        abort_run();
        fill_random();
        do_run(1, 1'b0);

        // Boundary operands: all maximum values
        for (int e = 0; e < NN; e++) begin
            a_mem[e] = 255;
            b_mem[e] = 255;
        end
        do_run(1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL global_timeout: got=1 expected=0");
        $fatal(1, "bench timeout");
    end

endmodule : tb_matmul_sequencer

`default_nettype wire
